// File: rtl/mini_src_pkg.sv
// mini_src_pkg: shared opcode constants, FSM state encoding and op-class enum
// for the Mini-SRC control sequencer.
package mini_src_pkg;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {HALT_S, T0, T1, T2, T3, T4, T5, T6} state_t;

   typedef enum logic [2:0] {RTYPE, MULDIV, NOP, HALT, ILLEGAL} op_cls_t;
endpackage

// File: rtl/cu_decode.sv
// cu_decode: opcode to op-class map; MUL/DIV are only recognised when
// CU_MULDIV_EN is defined, otherwise they decode as ILLEGAL.
import mini_src_pkg::*;

module cu_decode (
   input  logic [4:0] i_opcode,
   output op_cls_t    o_cls
);
   always_comb begin
      case (i_opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL: o_cls = RTYPE;
`ifdef CU_MULDIV_EN
         OP_MUL, OP_DIV:                  o_cls = MULDIV;
`endif
         OP_NOP:                          o_cls = NOP;
         OP_HALT:                         o_cls = HALT;
         default:                         o_cls = ILLEGAL;
      endcase
   end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Mini-SRC control FSM (fetch T0-T2, execute T3-T6).
// Optional MUL/DIV sequence enabled by defining CU_MULDIV_EN.
import mini_src_pkg::*;

module control_sequencer #(
   parameter int OPW = 5
) (
   input  logic           clock,
   input  logic           clear,
   input  logic           start,
   input  logic           stop,
   input  logic           mem_ready,
   input  logic [31:0]    IR,
   output logic           PCout,
   output logic           Zhighout,
   output logic           Zlowout,
   output logic           MDRout,
   output logic           HIout,
   output logic           LOout,
   output logic           MARin,
   output logic           PCin,
   output logic           MDRin,
   output logic           IRin,
   output logic           Yin,
   output logic           Zhighin,
   output logic           Zlowin,
   output logic           HIin,
   output logic           LOin,
   output logic           IncPC,
   output logic           Read,
   output logic           Gra,
   output logic           Grb,
   output logic           Grc,
   output logic           Rin,
   output logic           Rout,
   output logic [OPW-1:0] alu_op,
   output logic           run,
   output logic           illegal_op
);
   state_t  r_state;
   state_t  w_next;
   state_t  w_eoi;
   op_cls_t w_cls;
   logic    r_stop_pend;
   logic    r_illegal;
   logic    w_rt;
   logic    w_md;
   logic    w_unused_ir;

   cu_decode u_dec (
      .i_opcode (IR[31:27]),
      .o_cls    (w_cls)
   );

   assign w_rt        = w_cls == RTYPE;
   assign w_md        = w_cls == MULDIV;
   assign w_unused_ir = ^IR[26:0];
   // a stop arriving in the final execute cycle still counts as seen
   assign w_eoi       = (r_stop_pend || stop) ? HALT_S : T0;

   always_comb begin
      w_next = r_state;
      case (r_state)
         HALT_S:  w_next = (start && !stop) ? T0 : HALT_S;
         T0:      w_next = T1;
         T1:      w_next = mem_ready ? T2 : T1;
         T2:      w_next = T3;
         T3:      w_next = (w_cls == HALT) ? HALT_S : (w_rt || w_md) ? T4 : w_eoi;
         T4:      w_next = T5;
         T5:      w_next = w_md ? T6 : w_eoi;
`ifdef CU_MULDIV_EN
         T6:      w_next = w_eoi;
`endif
         default: w_next = HALT_S;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_state     <= HALT_S;
         r_stop_pend <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_stop_pend <= (r_state != HALT_S) && (w_next != HALT_S) && (r_stop_pend || stop);
         if (r_state == T3 && w_cls == ILLEGAL) r_illegal <= 1'b1;
      end
   end

   assign PCout      = r_state == T0;
   assign MARin      = r_state == T0;
   assign IncPC      = r_state == T0;
   assign Zlowin     = r_state == T0 || r_state == T4;
   assign Zlowout    = r_state == T1 || r_state == T5;
   assign PCin       = r_state == T1 && mem_ready;
   assign Read       = r_state == T1;
   assign MDRin      = r_state == T1;
   assign MDRout     = r_state == T2;
   assign IRin       = r_state == T2;
   assign Yin        = r_state == T3 && (w_rt || w_md);
   assign Rout       = (r_state == T3 || r_state == T4) && (w_rt || w_md);
   assign Gra        = (r_state == T3 && w_md) || (r_state == T5 && w_rt);
   assign Grb        = (r_state == T3 && w_rt) || (r_state == T4 && w_md);
   assign Grc        = r_state == T4 && w_rt;
   assign Rin        = r_state == T5 && w_rt;
   assign Zhighin    = r_state == T4 && w_md;
   assign LOin       = r_state == T5 && w_md;
   assign Zhighout   = r_state == T6 && w_md;
   assign HIin       = r_state == T6 && w_md;
   assign HIout      = 1'b0;
   assign LOout      = 1'b0;
   assign alu_op     = (r_state == T4) ? IR[31:32-OPW] : '0;
   assign run        = r_state != HALT_S;
   assign illegal_op = r_illegal;
endmodule
